// File: rtl/alu_exec_unit.sv
// Integer/branch execute unit: one op per cycle, result one cycle later.
// Optional perf counters under ALU_PERF_EN.
module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 4,
  parameter int OP_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 work_en,
  input  logic [OP_W-1:0]      opcode_from_rs,
  input  logic [ROB_IDX_W-1:0] rob_id_from_rs,
  input  logic [XLEN-1:0]      val1,
  input  logic [XLEN-1:0]      val2,
  input  logic [XLEN-1:0]      imm_from_rs,
  input  logic [XLEN-1:0]      pc_from_rs,
  output logic                 is_alu_ok,
  output logic [ROB_IDX_W-1:0] rob_id_from_alu,
  output logic [XLEN-1:0]      res_from_alu,
  output logic                 is_jump,
  output logic [XLEN-1:0]      jump_addr,
`ifdef ALU_PERF_EN
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_taken,
`endif
  output logic                 illegal_op
);

  localparam logic [OP_W-1:0] OP_LUI   = 6'd0;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd1;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd2;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd3;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd6;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd7;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd8;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd9;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd18;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd20;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd21;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd22;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd23;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd24;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd25;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd26;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd27;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd28;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd31;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd32;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd34;
  localparam logic [OP_W-1:0] OP_OR    = 6'd35;
  localparam logic [OP_W-1:0] OP_AND   = 6'd36;

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] a_imm;
  logic [4:0]      sh_i;
  logic [4:0]      sh_r;
  logic            eq;
  logic            lt;
  logic            ltu;

  assign pc4    = pc_from_rs + 32'd4;
  assign pc_imm = pc_from_rs + imm_from_rs;
  assign a_imm  = val1 + imm_from_rs;
  assign sh_i   = imm_from_rs[4:0];
  assign sh_r   = val2[4:0];
  assign eq     = (val1 == val2);
  assign lt     = ($signed(val1) < $signed(val2));
  assign ltu    = (val1 < val2);

  logic [XLEN-1:0] res_n;
  logic [XLEN-1:0] jaddr_n;
  logic            jump_n;
  logic            taken;
  logic            is_br;
  logic            legal;

  always_comb begin
    res_n   = '0;
    jaddr_n = pc4;
    jump_n  = 1'b0;
    taken   = 1'b0;
    is_br   = 1'b0;
    legal   = 1'b1;
    case (opcode_from_rs)
      OP_LUI:   res_n = imm_from_rs;
      OP_AUIPC: res_n = pc_imm;
      OP_JAL: begin
        res_n   = pc4;
        jump_n  = 1'b1;
        jaddr_n = pc_imm;
      end
      OP_JALR: begin
        res_n   = pc4;
        jump_n  = 1'b1;
        jaddr_n = {a_imm[XLEN-1:1], 1'b0};
      end
      OP_BEQ:  begin is_br = 1'b1; taken = eq;   end
      OP_BNE:  begin is_br = 1'b1; taken = !eq;  end
      OP_BLT:  begin is_br = 1'b1; taken = lt;   end
      OP_BGE:  begin is_br = 1'b1; taken = !lt;  end
      OP_BLTU: begin is_br = 1'b1; taken = ltu;  end
      OP_BGEU: begin is_br = 1'b1; taken = !ltu; end
      OP_ADDI:  res_n = a_imm;
      OP_SLTI:
        res_n = {31'd0,
          $signed(val1) < $signed(imm_from_rs)};
      OP_SLTIU:
        res_n = {31'd0, val1 < imm_from_rs};
      OP_XORI:  res_n = val1 ^ imm_from_rs;
      OP_ORI:   res_n = val1 | imm_from_rs;
      OP_ANDI:  res_n = val1 & imm_from_rs;
      OP_SLLI:  res_n = val1 << sh_i;
      OP_SRLI:  res_n = val1 >> sh_i;
      OP_SRAI:  res_n = $signed(val1) >>> sh_i;
      OP_ADD:   res_n = val1 + val2;
      OP_SUB:   res_n = val1 - val2;
      OP_SLL:   res_n = val1 << sh_r;
      OP_SLT:   res_n = {31'd0, lt};
      OP_SLTU:  res_n = {31'd0, ltu};
      OP_XOR:   res_n = val1 ^ val2;
      OP_SRL:   res_n = val1 >> sh_r;
      OP_SRA:   res_n = $signed(val1) >>> sh_r;
      OP_OR:    res_n = val1 | val2;
      OP_AND:   res_n = val1 & val2;
      default:  legal = 1'b0;
    endcase
    if (is_br) begin
      res_n   = {31'd0, taken};
      jump_n  = taken;
      jaddr_n = taken ? pc_imm : pc4;
    end
  end

  logic accept;
  assign accept = rdy && !clear && work_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_alu_ok       <= 1'b0;
      is_jump         <= 1'b0;
      illegal_op      <= 1'b0;
      rob_id_from_alu <= '0;
      res_from_alu    <= '0;
      jump_addr       <= '0;
    end else if (rdy) begin
      // data outputs keep their last value unless a legal op lands
      is_alu_ok  <= accept && legal;
      illegal_op <= accept && !legal;
      if (clear) begin
        is_jump <= 1'b0;
      end else if (accept && legal) begin
        rob_id_from_alu <= rob_id_from_rs;
        res_from_alu    <= res_n;
        is_jump         <= jump_n;
        jump_addr       <= jaddr_n;
      end
    end
  end

`ifdef ALU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_taken <= '0;
    end else if (accept && legal) begin
      perf_ops <= perf_ops + 32'd1;
      if (jump_n)
        perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule
